// File: rtl/dp_app_lb_bridge.sv
// CPU data-port to local-bus bridge: turns held CPU requests into single-cycle
// LB strobes, waits (with timeout) for LB read data, and keeps sticky error status.
module dp_app_lb_bridge #(
    parameter int          P_TIMEOUT = 255,
    parameter logic [31:0] P_ERR_DAT = 32'hDEADBEEF,
    parameter int          P_LB_ADR  = 22
) (
    input  logic                CLK_IN,
    input  logic                RST_IN,
    input  logic [31:0]         CPU_ADR_IN,
    input  logic [31:0]         CPU_DAT_IN,
    input  logic [3:0]          CPU_MSK_IN,
    input  logic                CPU_WR_IN,
    input  logic                CPU_REQ_IN,
    output logic                CPU_ACK_OUT,
    output logic [31:0]         CPU_DAT_OUT,
    output logic [P_LB_ADR-1:0] LB_ADR_OUT,
    output logic [31:0]         LB_DAT_OUT,
    output logic                LB_WR_OUT,
    output logic                LB_RD_OUT,
    input  logic [31:0]         LB_DAT_IN,
    input  logic                LB_VLD_IN,
    output logic                ERR_OUT,
    output logic [1:0]          ERR_CAUSE_OUT,
    output logic [31:0]         ERR_ADR_OUT,
    input  logic                ERR_CLR_IN
);

    localparam int            CW      = $clog2(P_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(P_TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WR   = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
    localparam logic [1:0] CAUSE_PARTIAL = 2'b10;

    logic [1:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic [31:0]   adr_r;

    // Transaction FSM, registered bus outputs and sticky error status.
    // A clear is scheduled first so that a same-cycle new error overrides it.
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state_r       <= S_IDLE;
            cnt_r         <= '0;
            adr_r         <= 32'h0000_0000;
            CPU_ACK_OUT   <= 1'b0;
            CPU_DAT_OUT   <= 32'h0000_0000;
            LB_ADR_OUT    <= '0;
            LB_DAT_OUT    <= 32'h0000_0000;
            LB_WR_OUT     <= 1'b0;
            LB_RD_OUT     <= 1'b0;
            ERR_OUT       <= 1'b0;
            ERR_CAUSE_OUT <= 2'b00;
            ERR_ADR_OUT   <= 32'h0000_0000;
        end else begin
            CPU_ACK_OUT <= 1'b0;
            LB_WR_OUT   <= 1'b0;
            LB_RD_OUT   <= 1'b0;
            if (ERR_CLR_IN) begin
                ERR_OUT       <= 1'b0;
                ERR_CAUSE_OUT <= 2'b00;
                ERR_ADR_OUT   <= 32'h0000_0000;
            end
            case (state_r)
                S_IDLE: begin
                    if (CPU_REQ_IN && CPU_ADR_IN[31]) begin
                        adr_r      <= CPU_ADR_IN;
                        LB_ADR_OUT <= CPU_ADR_IN[2 +: P_LB_ADR];
                        if (CPU_WR_IN) begin
                            // Partial writes still pass through WR so write latency stays fixed.
                            state_r    <= S_WR;
                            LB_DAT_OUT <= CPU_DAT_IN;
                            if (CPU_MSK_IN == 4'hF) begin
                                LB_WR_OUT <= 1'b1;
                            end else begin
                                ERR_OUT       <= 1'b1;
                                ERR_CAUSE_OUT <= CAUSE_PARTIAL;
                                ERR_ADR_OUT   <= CPU_ADR_IN;
                            end
                        end else begin
                            state_r   <= S_RD;
                            LB_RD_OUT <= 1'b1;
                            cnt_r     <= '0;
                        end
                    end
                end
                S_WR: begin
                    CPU_ACK_OUT <= 1'b1;
                    CPU_DAT_OUT <= 32'h0000_0000;
                    state_r     <= S_ACK;
                end
                S_RD: begin
                    if (LB_VLD_IN) begin
                        CPU_ACK_OUT <= 1'b1;
                        CPU_DAT_OUT <= LB_DAT_IN;
                        state_r     <= S_ACK;
                    end else if (cnt_r == CNT_MAX) begin
                        CPU_ACK_OUT   <= 1'b1;
                        CPU_DAT_OUT   <= P_ERR_DAT;
                        state_r       <= S_ACK;
                        ERR_OUT       <= 1'b1;
                        ERR_CAUSE_OUT <= CAUSE_TIMEOUT;
                        ERR_ADR_OUT   <= adr_r;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                S_ACK: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dp_app_lb_bridge.sv
// Self-checking bench for dp_app_lb_bridge: directed scenarios plus random
// transactions compared against a transaction-level reference model.
module tb_dp_app_lb_bridge;

    localparam int          T    = 8;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_adr = 32'h0;
    logic [31:0] cpu_dat = 32'h0;
    logic [3:0]  cpu_msk = 4'h0;
    logic        cpu_wr = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_ack;
    logic [31:0] cpu_dat_o;
    logic [21:0] lb_adr;
    logic [31:0] lb_dat_o;
    logic        lb_wr;
    logic        lb_rd;
    logic [31:0] lb_dat_i = 32'h0;
    logic        lb_vld = 1'b0;
    logic        err;
    logic [1:0]  err_cause;
    logic [31:0] err_adr;
    logic        err_clr = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model of the externally visible state.
    logic        m_err   = 1'b0;
    logic [1:0]  m_cause = 2'b00;
    logic [31:0] m_eadr  = 32'h0;
    logic [31:0] m_cdat  = 32'h0;

    always #5 clk = ~clk;

    dp_app_lb_bridge #(.P_TIMEOUT(T), .P_ERR_DAT(ERRD), .P_LB_ADR(22)) dut (
        .CLK_IN(clk), .RST_IN(rst),
        .CPU_ADR_IN(cpu_adr), .CPU_DAT_IN(cpu_dat), .CPU_MSK_IN(cpu_msk),
        .CPU_WR_IN(cpu_wr), .CPU_REQ_IN(cpu_req),
        .CPU_ACK_OUT(cpu_ack), .CPU_DAT_OUT(cpu_dat_o),
        .LB_ADR_OUT(lb_adr), .LB_DAT_OUT(lb_dat_o),
        .LB_WR_OUT(lb_wr), .LB_RD_OUT(lb_rd),
        .LB_DAT_IN(lb_dat_i), .LB_VLD_IN(lb_vld),
        .ERR_OUT(err), .ERR_CAUSE_OUT(err_cause), .ERR_ADR_OUT(err_adr),
        .ERR_CLR_IN(err_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_err();
        check("err_flag", 32'(err), 32'(m_err));
        check("err_cause", 32'(err_cause), 32'(m_cause));
        check("err_adr", err_adr, m_eadr);
    endtask

    task automatic set_err(input logic [1:0] cause, input logic [31:0] a);
        m_err   = 1'b1;
        m_cause = cause;
        m_eadr  = a;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] m, input int skip);
        logic full;
        full    = (m == 4'hF);
        cpu_adr = a; cpu_dat = d; cpu_msk = m; cpu_wr = 1'b1; cpu_req = 1'b1;
        for (int i = 0; i < skip; i++) begin
            @(negedge clk);
            check("b2b_wr_held", 32'(lb_wr), 32'd0);
            check("b2b_wr_noack", 32'(cpu_ack), 32'd0);
        end
        @(negedge clk);
        cpu_dat = ~d; cpu_adr = a ^ 32'h0000_0FF0; cpu_msk = ~m;
        check("wr_strobe", 32'(lb_wr), 32'(full));
        check("wr_norack", 32'(cpu_ack), 32'd0);
        check("wr_nord", 32'(lb_rd), 32'd0);
        if (full) begin
            check("wr_lb_adr", 32'(lb_adr), 32'(a[23:2]));
            check("wr_lb_dat", lb_dat_o, d);
        end else begin
            set_err(2'b10, a);
        end
        @(negedge clk);
        check("wr_ack", 32'(cpu_ack), 32'd1);
        check("wr_ack_dat", cpu_dat_o, 32'h0);
        check("wr_strobe_end", 32'(lb_wr), 32'd0);
        m_cdat = 32'h0;
        chk_err();
        cpu_req = 1'b0; cpu_wr = 1'b0;
    endtask

    // dly: cycles after the rd strobe at which vld is driven; outside 0..T means none.
    task automatic do_read(input logic [31:0] a, input logic [31:0] d, input int dly,
                           input int skip, input logic clr_at_to);
        logic ok;
        int   ackc;
        logic [31:0] exp;
        ok   = (dly >= 0 && dly <= T);
        ackc = ok ? dly + 1 : T + 1;
        cpu_adr = a; cpu_wr = 1'b0; cpu_msk = 4'($urandom); cpu_req = 1'b1;
        for (int i = 0; i < skip; i++) begin
            @(negedge clk);
            check("b2b_rd_held", 32'(lb_rd), 32'd0);
            check("b2b_rd_noack", 32'(cpu_ack), 32'd0);
        end
        for (int c = 0; c < ackc; c++) begin
            @(negedge clk);
            lb_vld = 1'b0; err_clr = 1'b0;
            if (c == 0) begin
                cpu_adr = ~a; cpu_wr = 1'b1;
                check("rd_strobe", 32'(lb_rd), 32'd1);
                check("rd_lb_adr", 32'(lb_adr), 32'(a[23:2]));
            end else begin
                check("rd_single_strobe", 32'(lb_rd), 32'd0);
            end
            check("rd_noack", 32'(cpu_ack), 32'd0);
            check("rd_nowr", 32'(lb_wr), 32'd0);
            if (c == dly) begin
                lb_vld = 1'b1; lb_dat_i = d;
            end else begin
                lb_dat_i = $urandom;
            end
            if (clr_at_to && c == T) err_clr = 1'b1;
        end
        @(negedge clk);
        lb_vld = 1'b0; err_clr = 1'b0;
        exp = ok ? d : ERRD;
        check("rd_ack", 32'(cpu_ack), 32'd1);
        check("rd_data", cpu_dat_o, exp);
        m_cdat = exp;
        if (!ok) set_err(2'b01, a);
        chk_err();
        cpu_req = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic idle(input int n, input logic stray);
        for (int i = 0; i < n; i++) begin
            cpu_req = stray; cpu_adr = 32'h0000_1000; cpu_wr = 1'b0;
            lb_vld = stray; lb_dat_i = $urandom;
            @(negedge clk);
            check("idle_noack", 32'(cpu_ack), 32'd0);
            check("idle_nord", 32'(lb_rd), 32'd0);
            check("idle_nowr", 32'(lb_wr), 32'd0);
            check("idle_dat_hold", cpu_dat_o, m_cdat);
            chk_err();
        end
        cpu_req = 1'b0; lb_vld = 1'b0;
    endtask

    task automatic clr_pulse();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err = 1'b0; m_cause = 2'b00; m_eadr = 32'h0;
        chk_err();
    endtask

    initial begin
        logic [31:0] r;
        int          dly;
        logic [3:0]  m;

        repeat (2) @(negedge clk);
        check("rst_ack", 32'(cpu_ack), 32'd0);
        check("rst_cdat", cpu_dat_o, 32'h0);
        check("rst_lbadr", 32'(lb_adr), 32'h0);
        check("rst_lbdat", lb_dat_o, 32'h0);
        check("rst_wr", 32'(lb_wr), 32'd0);
        check("rst_rd", 32'(lb_rd), 32'd0);
        chk_err();
        rst = 1'b0;
        @(negedge clk);

        do_write(32'h8000_0010, 32'h1234_5678, 4'hF, 0);
        idle(1, 1'b0);
        do_read(32'h8000_0040, 32'hCAFE_0001, 3, 0, 1'b0);
        idle(1, 1'b0);
        do_read(32'h8000_0100, 32'h0, -1, 0, 1'b0);
        idle(1, 1'b0);
        clr_pulse();
        do_read(32'h8000_0100, 32'h5A5A_0F0F, T, 0, 1'b0);
        idle(1, 1'b0);

        do_write(32'h8000_0008, 32'hAAAA_5555, 4'h3, 0);
        idle(1, 1'b0);
        clr_pulse();
        do_write(32'h8000_000C, 32'h0BAD_0BAD, 4'h7, 0);
        idle(1, 1'b0);
        do_read(32'h8000_0200, 32'h0, -1, 0, 1'b1);
        idle(1, 1'b0);
        clr_pulse();

        idle(4, 1'b1);
        do_write(32'h8000_0020, 32'h0F0F_1234, 4'hF, 0);
        do_read(32'h8000_0024, 32'h7777_8888, 0, 1, 1'b0);
        idle(1, 1'b0);

        // Reset two cycles after the read strobe.
        cpu_adr = 32'h8000_0300; cpu_wr = 1'b0; cpu_req = 1'b1;
        @(negedge clk);
        check("rstrd_strobe", 32'(lb_rd), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstrd_ack", 32'(cpu_ack), 32'd0);
        check("rstrd_cdat", cpu_dat_o, 32'h0);
        check("rstrd_lbadr", 32'(lb_adr), 32'h0);
        check("rstrd_lbdat", lb_dat_o, 32'h0);
        check("rstrd_rd", 32'(lb_rd), 32'd0);
        check("rstrd_wr", 32'(lb_wr), 32'd0);
        m_err = 1'b0; m_cause = 2'b00; m_eadr = 32'h0; m_cdat = 32'h0;
        chk_err();
        cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0; lb_vld = 1'b1; lb_dat_i = 32'h1111_2222;
        @(negedge clk);
        lb_vld = 1'b0;
        check("rstrd_late_vld", 32'(cpu_ack), 32'd0);
        @(negedge clk);
        check("rstrd_late_vld2", 32'(cpu_ack), 32'd0);
        check("rstrd_late_dat", cpu_dat_o, 32'h0);
        do_write(32'h8000_0400, 32'h2468_ACE0, 4'hF, 0);
        idle(1, 1'b0);

        for (int k = 0; k < 24; k++) begin
            r = $urandom;
            r = r | 32'h8000_0000;
            if ($urandom_range(0, 1) == 0) begin
                m = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 14));
                do_write(r, $urandom, m, 0);
            end else begin
                dly = $urandom_range(0, T + 3);
                do_read(r, $urandom, dly, 0, 1'b0);
            end
            if ($urandom_range(0, 3) == 0) clr_pulse();
            idle(1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
